mem_arbiter: RTL and testbench

- Parametrised N-channel arbiter that shares one port of the dual-port main memory among several requesters: core fetch, core load/store, and later the caches.
- Each channel presents a valid/ready request and receives a one-cycle response pulse. Grants are round-robin.
- The arbiter drives the memory's addr/data_i/data_en/write_en port and returns data_o.
- One transaction is outstanding at a time. Memory read latency is a parameter.

---
 rtl/mem_arbiter_if.sv | 37 +++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 tb/tb_mem_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Request/response and memory-port bundle for mem_arbiter.
//   slave  : arbiter view (takes requests and mem_data_o, drives ready/resp/memory port)
//   master : environment view (requesters plus the memory model)
// req_* fields are packed per channel: channel c at [c*W +: W].
interface mem_arbiter_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned BE_W = DATA_W / 8;

  logic [NUM_CH-1:0]        req_valid;
  logic [NUM_CH-1:0]        req_ready;
  logic [NUM_CH*ADDR_W-1:0] req_addr;
  logic [NUM_CH*DATA_W-1:0] req_wdata;
  logic [NUM_CH*BE_W-1:0]   req_be;
  logic [NUM_CH-1:0]        req_we;
  logic [NUM_CH-1:0]        resp_valid;
  logic [DATA_W-1:0]        resp_rdata;
  logic [ADDR_W-1:0]        mem_addr;
  logic [DATA_W-1:0]        mem_data_i;
  logic [BE_W-1:0]          mem_data_en;
  logic                     mem_write_en;
  logic [DATA_W-1:0]        mem_data_o;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_be, req_we, mem_data_o,
    output req_ready, resp_valid, resp_rdata,
           mem_addr, mem_data_i, mem_data_en, mem_write_en
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_be, req_we, mem_data_o,
    input  req_ready, resp_valid, resp_rdata,
           mem_addr, mem_data_i, mem_data_en, mem_write_en
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin N-channel arbiter in front of one port of the main memory.
// One transaction is in flight at a time: IDLE -> ISSUE -> WAIT -> RESP.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mem_arbiter_if.slave -- per-channel valid/ready requests,
//                one-hot resp_valid pulse with shared resp_rdata, and the
//                memory addr/data_i/data_en/write_en/data_o port.
// req_ready is combinational (granted in the same IDLE cycle); every other
// output is registered.
module mem_arbiter #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  mem_arbiter_if.slave  bus
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned CNT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  // Only what is needed after ISSUE; addr/wdata/be live in the memory-port registers.
  typedef struct packed {
    logic            we;
    logic [CH_W-1:0] ch;
  } req_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  req_t              req_q, req_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_data_i_q, mem_data_i_d;
  logic [BE_W-1:0]   mem_data_en_q, mem_data_en_d;
  logic              mem_write_en_q, mem_write_en_d;

  logic              gnt_found;
  logic [CH_W-1:0]   gnt_idx;
  logic [CH_W-1:0]   cand;

  // Round-robin search: first valid channel at or above rr_ptr, wrapping.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand = CH_W'((32'(rr_ptr_q) + i) % NUM_CH);
      if (!gnt_found && bus.req_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  // Ready only in IDLE, so at most one channel sees it.
  always_comb begin
    bus.req_ready = '0;
    if (state_q == IDLE && gnt_found) begin
      bus.req_ready[gnt_idx] = 1'b1;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    req_d          = req_q;
    cnt_d          = cnt_q;
    resp_valid_d   = '0;
    resp_rdata_d   = resp_rdata_q;
    mem_addr_d     = '0;
    mem_data_i_d   = '0;
    mem_data_en_d  = '0;
    mem_write_en_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (gnt_found) begin
          // Loading the port registers now makes them valid during ISSUE only.
          req_d.we       = bus.req_we[gnt_idx];
          req_d.ch       = gnt_idx;
          mem_addr_d     = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
          mem_data_i_d   = bus.req_wdata[gnt_idx*DATA_W +: DATA_W];
          mem_data_en_d  = bus.req_be[gnt_idx*BE_W +: BE_W];
          mem_write_en_d = bus.req_we[gnt_idx];
          rr_ptr_d       = (32'(gnt_idx) == NUM_CH - 1) ? '0 : gnt_idx + CH_W'(1);
          state_d        = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(MEM_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          resp_rdata_d            = req_q.we ? '0 : bus.mem_data_o;
          resp_valid_d[req_q.ch]  = 1'b1;
          state_d                 = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rr_ptr_q       <= '0;
      req_q          <= '0;
      cnt_q          <= '0;
      resp_valid_q   <= '0;
      resp_rdata_q   <= '0;
      mem_addr_q     <= '0;
      mem_data_i_q   <= '0;
      mem_data_en_q  <= '0;
      mem_write_en_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      req_q          <= req_d;
      cnt_q          <= cnt_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_data_i_q   <= mem_data_i_d;
      mem_data_en_q  <= mem_data_en_d;
      mem_write_en_q <= mem_write_en_d;
    end
  end

  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = resp_rdata_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_data_i   = mem_data_i_q;
  assign bus.mem_data_en  = mem_data_en_q;
  assign bus.mem_write_en = mem_write_en_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance with MEM_LATENCY=1 (b1) and
// one with MEM_LATENCY=3 (b3), each backed by a small behavioural memory.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int wr_cycles = 0;
  int w0;

  mem_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) b1 ();
  mem_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) b3 ();

  mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1));
  mem_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .MEM_LATENCY(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(b3));

  // Memory models: word i initialised to 0x1000_0000+i, word 2 = 0xAAAAAAAA, word 16 = 0xDEADBEEF.
  logic [31:0] m1 [64];
  logic [31:0] m3 [64];
  logic [31:0] p0, p1;

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m1[i] <= 32'h1000_0000 + 32'(i);
      m1[2]  <= 32'hAAAA_AAAA;
      m1[16] <= 32'hDEAD_BEEF;
      b1.mem_data_o <= '0;
    end else begin
      if (b1.mem_write_en)
        for (int b = 0; b < 4; b++)
          if (b1.mem_data_en[b]) m1[b1.mem_addr[7:2]][8*b +: 8] <= b1.mem_data_i[8*b +: 8];
      b1.mem_data_o <= (|b1.mem_data_en && !b1.mem_write_en) ? m1[b1.mem_addr[7:2]] : 32'h0;
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) m3[i] <= 32'h1000_0000 + 32'(i);
      m3[2]  <= 32'hAAAA_AAAA;
      m3[16] <= 32'hDEAD_BEEF;
      p0 <= '0;
      p1 <= '0;
      b3.mem_data_o <= '0;
    end else begin
      if (b3.mem_write_en)
        for (int b = 0; b < 4; b++)
          if (b3.mem_data_en[b]) m3[b3.mem_addr[7:2]][8*b +: 8] <= b3.mem_data_i[8*b +: 8];
      p0 <= (|b3.mem_data_en && !b3.mem_write_en) ? m3[b3.mem_addr[7:2]] : 32'h0;
      p1 <= p0;
      b3.mem_data_o <= p1;
    end
  end

  always @(negedge clk) if (b1.mem_write_en) wr_cycles++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input bit sel3, input int c, input logic v, input logic [31:0] a,
                     input logic [3:0] be, input logic we, input logic [31:0] wd);
    if (sel3) begin
      b3.req_valid[c] = v;
      b3.req_addr[c*32 +: 32]  = a;
      b3.req_wdata[c*32 +: 32] = wd;
      b3.req_be[c*4 +: 4]      = be;
      b3.req_we[c]             = we;
    end else begin
      b1.req_valid[c] = v;
      b1.req_addr[c*32 +: 32]  = a;
      b1.req_wdata[c*32 +: 32] = wd;
      b1.req_be[c*4 +: 4]      = be;
      b1.req_we[c]             = we;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    b1.req_valid = '0; b1.req_addr = '0; b1.req_wdata = '0; b1.req_be = '0; b1.req_we = '0;
    b3.req_valid = '0; b3.req_addr = '0; b3.req_wdata = '0; b3.req_be = '0; b3.req_we = '0;

    // Reset held three cycles: every output quiet.
    repeat (3) begin
      smp();
      chk("rst_ready", 64'(b1.req_ready), 64'h0);
      chk("rst_resp_valid", 64'(b1.resp_valid), 64'h0);
      chk("rst_rdata", 64'(b1.resp_rdata), 64'h0);
      chk("rst_mem_addr", 64'(b1.mem_addr), 64'h0);
      chk("rst_mem_data_i", 64'(b1.mem_data_i), 64'h0);
      chk("rst_mem_en", 64'(b1.mem_data_en), 64'h0);
      chk("rst_mem_we", 64'(b1.mem_write_en), 64'h0);
      chk("rst_rr_ptr", 64'(dut1.rr_ptr_q), 64'h0);
    end
    tick(); rst_n = 1'b1;
    repeat (2) begin
      smp();
      chk("idle_mem_en", 64'(b1.mem_data_en), 64'h0);
      chk("idle_ready", 64'(b1.req_ready), 64'h0);
    end

    // Single read, ch2 @0x40.
    tick(); drv(0, 2, 1'b1, 32'h40, 4'hF, 1'b0, 32'h0);
    smp(); chk("rd_ready", 64'(b1.req_ready), 64'h4);
    tick(); drv(0, 2, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp();
    chk("rd_issue_addr", 64'(b1.mem_addr), 64'h40);
    chk("rd_issue_en", 64'(b1.mem_data_en), 64'hF);
    chk("rd_issue_we", 64'(b1.mem_write_en), 64'h0);
    chk("rd_issue_ready", 64'(b1.req_ready), 64'h0);
    tick(); smp();
    chk("rd_wait_en", 64'(b1.mem_data_en), 64'h0);
    chk("rd_wait_addr", 64'(b1.mem_addr), 64'h0);
    chk("rd_wait_resp", 64'(b1.resp_valid), 64'h0);
    tick(); smp();
    chk("rd_resp_valid", 64'(b1.resp_valid), 64'h4);
    chk("rd_resp_rdata", 64'(b1.resp_rdata), 64'hDEAD_BEEF);
    tick(); smp();
    chk("rd_after_valid", 64'(b1.resp_valid), 64'h0);
    chk("rd_hold_rdata", 64'(b1.resp_rdata), 64'hDEAD_BEEF);

    // Partial write ch0 @0x8, then read back.
    w0 = wr_cycles;
    tick(); drv(0, 0, 1'b1, 32'h8, 4'b0011, 1'b1, 32'h1234_5678);
    smp(); chk("wr_ready", 64'(b1.req_ready), 64'h1);
    tick(); drv(0, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp();
    chk("wr_issue_we", 64'(b1.mem_write_en), 64'h1);
    chk("wr_issue_data", 64'(b1.mem_data_i), 64'h1234_5678);
    chk("wr_issue_en", 64'(b1.mem_data_en), 64'h3);
    chk("wr_issue_addr", 64'(b1.mem_addr), 64'h8);
    tick(); smp(); chk("wr_wait_we", 64'(b1.mem_write_en), 64'h0);
    tick(); smp();
    chk("wr_resp_valid", 64'(b1.resp_valid), 64'h1);
    chk("wr_resp_rdata", 64'(b1.resp_rdata), 64'h0);
    tick(); drv(0, 0, 1'b1, 32'h8, 4'hF, 1'b0, 32'h0);
    smp(); chk("rb_ready", 64'(b1.req_ready), 64'h1);
    tick(); drv(0, 0, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp(); tick(); smp(); tick(); smp();
    chk("rb_resp_valid", 64'(b1.resp_valid), 64'h1);
    chk("rb_resp_rdata", 64'(b1.resp_rdata), 64'hAAAA_5678);
    chk("wr_cycles", 64'(wr_cycles - w0), 64'h1);

    // Zero byte enables: no-op access still completes (rr_ptr now 1).
    tick(); drv(0, 1, 1'b1, 32'h40, 4'h0, 1'b0, 32'h0);
    smp(); chk("be0_ready", 64'(b1.req_ready), 64'h2);
    tick(); drv(0, 1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp();
    chk("be0_issue_en", 64'(b1.mem_data_en), 64'h0);
    chk("be0_issue_addr", 64'(b1.mem_addr), 64'h40);
    tick(); smp(); tick(); smp();
    chk("be0_resp_valid", 64'(b1.resp_valid), 64'h2);
    chk("be0_resp_rdata", 64'(b1.resp_rdata), 64'h0);

    // Short reset pulse to bring rr_ptr back to 0.
    tick(); rst_n = 1'b0;
    smp(); chk("pulse_rr_ptr", 64'(dut1.rr_ptr_q), 64'h0);
    tick(); rst_n = 1'b1;

    // Round-robin: all four channels valid continuously.
    tick();
    for (int c = 0; c < 4; c++) drv(0, c, 1'b1, 32'hC0 + 32'(4*c), 4'hF, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      smp(); chk("rr_ready", 64'(b1.req_ready), 64'(4'b0001 << (k % 4)));
      tick();
      if (k == 4) for (int c = 0; c < 4; c++) drv(0, c, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
      smp(); tick(); smp(); tick(); smp();
      chk("rr_resp_valid", 64'(b1.resp_valid), 64'(4'b0001 << (k % 4)));
      chk("rr_resp_rdata", 64'(b1.resp_rdata), 64'(32'h1000_0030 + 32'(k % 4)));
      tick();
    end
    smp();
    chk("rr_idle_ready", 64'(b1.req_ready), 64'h0);
    chk("rr_final_ptr", 64'(dut1.rr_ptr_q), 64'h1);

    // MEM_LATENCY = 3: ch1 read, response 5 cycles after handshake.
    tick(); drv(1, 1, 1'b1, 32'h40, 4'hF, 1'b0, 32'h0);
    smp(); chk("l3_ready", 64'(b3.req_ready), 64'h2);
    tick(); drv(1, 1, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp();
    chk("l3_issue_addr", 64'(b3.mem_addr), 64'h40);
    chk("l3_issue_en", 64'(b3.mem_data_en), 64'hF);
    for (int w = 0; w < 3; w++) begin
      tick(); smp();
      chk("l3_wait_en", 64'(b3.mem_data_en), 64'h0);
      chk("l3_wait_addr", 64'(b3.mem_addr), 64'h0);
      chk("l3_wait_resp", 64'(b3.resp_valid), 64'h0);
    end
    tick(); smp();
    chk("l3_resp_valid", 64'(b3.resp_valid), 64'h2);
    chk("l3_resp_rdata", 64'(b3.resp_rdata), 64'hDEAD_BEEF);

    // Reset during WAIT for ch3 (rr_ptr is 1, so ch3 wins).
    tick(); drv(0, 3, 1'b1, 32'h40, 4'hF, 1'b0, 32'h0);
    smp(); chk("mid_ready", 64'(b1.req_ready), 64'h8);
    tick(); drv(0, 3, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp(); chk("mid_issue_addr", 64'(b1.mem_addr), 64'h40);
    tick(); rst_n = 1'b0;
    smp();
    chk("mid_rst_resp", 64'(b1.resp_valid), 64'h0);
    chk("mid_rst_rr_ptr", 64'(dut1.rr_ptr_q), 64'h0);
    tick(); smp(); chk("mid_rst_resp2", 64'(b1.resp_valid), 64'h0);
    tick(); rst_n = 1'b1;
    smp();
    chk("mid_rel_resp", 64'(b1.resp_valid), 64'h0);
    chk("mid_rel_rr_ptr", 64'(dut1.rr_ptr_q), 64'h0);
    tick(); drv(0, 3, 1'b1, 32'h40, 4'hF, 1'b0, 32'h0);
    smp(); chk("mid_regrant", 64'(b1.req_ready), 64'h8);
    tick(); drv(0, 3, 1'b0, 32'h0, 4'h0, 1'b0, 32'h0);
    smp(); tick(); smp(); tick(); smp();
    chk("mid_resp_valid", 64'(b1.resp_valid), 64'h8);
    chk("mid_resp_rdata", 64'(b1.resp_rdata), 64'hDEAD_BEEF);
    chk("mid_rr_ptr", 64'(dut1.rr_ptr_q), 64'h0);
    tick(); smp(); chk("mid_after_resp", 64'(b1.resp_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
